// File: rtl/vedic_mac_accumulator.sv
// rtl/vedic_mac_accumulator.sv - three-stage stall-able multiply-accumulate around a 32x32 vedic multiplier
// Terms are summed per in_last-delimited group; one result register feeds the consumer.

module vedic_multiplier (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] s
);
   logic [31:0] p_ll, p_lh, p_hl, p_hh;

   // Vertical-and-crosswise split into four 16x16 partial products
   assign p_ll = {16'b0, a[15:0]}  * {16'b0, b[15:0]};
   assign p_lh = {16'b0, a[15:0]}  * {16'b0, b[31:16]};
   assign p_hl = {16'b0, a[31:16]} * {16'b0, b[15:0]};
   assign p_hh = {16'b0, a[31:16]} * {16'b0, b[31:16]};

   assign s = {p_hh, p_ll} + {16'b0, p_lh, 16'b0} + {16'b0, p_hl, 16'b0};
endmodule

module vedic_mac_accumulator #(
   parameter int ACC_W = 80,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);
   logic             stall;
   logic             s0_valid, s0_last;
   logic [31:0]      s0_a, s0_b;
   logic [63:0]      mul_s;
   logic             s1_valid, s1_last;
   logic [63:0]      s1_prod;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             first;

   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   sum_ext;
   logic             sum_ovf;
   logic [CNT_W-1:0] cnt_base, cnt_next;
   logic             take;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall && !flush;
   assign take     = !stall && s1_valid;

   vedic_multiplier u_mul (
      .a (s0_a),
      .b (s0_b),
      .s (mul_s)
   );

   // A group's first term ignores whatever acc/ovf/cnt the previous group left behind
   always_comb begin
      acc_base = first ? '0 : acc_q;
      cnt_base = first ? '0 : cnt_q;
      sum_ext  = {1'b0, acc_base} + {{(ACC_W-63){1'b0}}, s1_prod};
      sum_ovf  = (!first && ovf_q) || sum_ext[ACC_W];
      cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_last  <= 1'b0;
         s0_a     <= '0;
         s0_b     <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_prod  <= '0;
      end else if (flush) begin
         s0_valid <= 1'b0;
         s1_valid <= 1'b0;
      end else if (!stall) begin
         s0_valid <= in_valid;
         if (in_valid) begin
            s0_a    <= a;
            s0_b    <= b;
            s0_last <= in_last;
         end
         s1_valid <= s0_valid;
         s1_prod  <= mul_s;
         s1_last  <= s0_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         cnt_q        <= '0;
         first        <= 1'b1;
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else if (flush) begin
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         first     <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         if (take && s1_last) begin
            out_acc      <= sum_ext[ACC_W-1:0];
            out_count    <= cnt_next;
            out_overflow <= sum_ovf;
            out_valid    <= 1'b1;
            acc_q        <= '0;
            first        <= 1'b1;
         end else begin
            if (take) begin
               acc_q <= sum_ext[ACC_W-1:0];
               ovf_q <= sum_ovf;
               cnt_q <= cnt_next;
               first <= 1'b0;
            end
            if (out_valid && out_ready)
               out_valid <= 1'b0;
         end
      end
   end
endmodule
